tile_draw_arbiter: RTL and testbench
====================================

// Module: tile_draw_arbiter
// PURPOSE
//  Shares the single vga_adapter pixel-write port among NREQ tile renderers (snake head, body eraser, apple).
//  Each renderer requests one XDIM x YDIM filled square at (x,y) in a colour. The block grants requesters
//  round-robin and sweeps the square row-major, one pixel per clock. It drives VGA_X/VGA_Y/VGA_COLOR/plot.
//  This replaces the per-object XC/YC counter pairs and draw/erase FSM states in the top level.
// PARAMETERS
//  NREQ     3    number of requesters (2..8)
//  XDIM     10   tile width, pixels (1..16)
//  YDIM     10   tile height, pixels (1..16)
//  XSCREEN  160  screen width; used for clipping
//  YSCREEN  120  screen height; used for clipping
// PORTS
//  Clock       in   1        system clock (CLOCK_50); all logic on posedge
//  Reset       in   1        synchronous, active-high reset
//  req         in   NREQ     per-requester draw request; level, held until grant
//  req_x       in   8*NREQ   tile origin X; requester i in bits [8i+7:8i]
//  req_y       in   7*NREQ   tile origin Y; requester i in bits [7i+6:7i]
//  req_colour  in   3*NREQ   tile colour; requester i in bits [3i+2:3i]
//  grant       out  NREQ     one-hot, 1-cycle pulse: request accepted, inputs latched
//  done        out  NREQ     one-hot, 1-cycle pulse: last pixel of granted tile written
//  busy        out  1        high whenever state != IDLE
//  VGA_X       out  8        pixel X to adapter
//  VGA_Y       out  7        pixel Y to adapter
//  VGA_COLOR   out  3        pixel colour to adapter
//  plot        out  1        adapter write strobe
// BEHAVIOUR
//  - States: IDLE, DRAW, DONE. Reset (any cycle, including mid-DRAW) forces IDLE. It also clears grant, done,
//    plot, busy, XC, YC, latched x/y/colour and the rr pointer (=0). VGA_X/VGA_Y/VGA_COLOR read 0 after reset.
//  - IDLE: if |req is high, pick the first asserted index searching ptr, ptr+1, ... mod NREQ.
//    At the clock edge: latch that requester's x/y/colour, set grant[i]=1, set ptr=(i+1) mod NREQ,
//    clear XC and YC, and go to DRAW. If no req is high, stay in IDLE with all strobes 0.
//  - DRAW: grant is high in the first DRAW cycle only. Each cycle VGA_X=bx+XC and VGA_Y=by+YC.
//    Sum widths: 8-bit X and 7-bit Y, truncated. VGA_COLOR=latched colour.
//    XC increments 0..XDIM-1; at XDIM-1 it wraps to 0 and YC increments.
//    When XC==XDIM-1 and YC==YDIM-1, go to DONE. DRAW lasts exactly XDIM*YDIM cycles.
//  - DONE: one cycle; done[i]=1, plot=0, busy=1; next state IDLE unconditionally.
//  - A granted tile always completes: 1 + XDIM*YDIM + 1 cycles from acceptance edge to IDLE (102 at default).
//  - Changes to req, req_x, req_y or req_colour after grant do not affect the tile in flight.
//  - A requester dropping req before grant withdraws with no side effects.
//  - Arbitration runs only in IDLE. A req asserted during DRAW or DONE waits.
//  - Back-to-back grants are separated by the DONE cycle and one IDLE cycle.
//  - Simultaneous requests: only one grant per arbitration. With all NREQ=3 held continuously,
//    grant order is 0,1,2,0,...; no requester starves.
//  - Outputs are combinational from registered state/counters/latches; no output depends on req combinationally.
//  - plot=0 in IDLE and DONE; VGA_* may hold stale values there.
// CONFIGURATION
//  TILE_ARB_CLIP_EN defined:
//    - In DRAW, plot=0 for any pixel whose unwrapped bx+XC >= XSCREEN or by+YC >= YSCREEN
//      (9-/8-bit compare before truncation).
//    - Cycle count, grant and done timing are unchanged.
//  TILE_ARB_CLIP_EN undefined:
//    - plot=1 for every DRAW cycle; coordinates wrap modulo 256/128 per width truncation.
// TESTING
//  1. Reset held 3 cycles, then released, no req:
//     -> busy=0, plot=0, grant=0, done=0, ptr=0 for 20 cycles.
//  2. req[1] with (x=80, y=60, colour=3'b100):
//     -> grant=3'b010 one cycle; plot=1 for 100 cycles, first pixel (80,60), last pixel (89,69),
//        colour 4 throughout; then done=3'b010 one cycle; busy low on the next cycle.
//  3. req=3'b111 held continuously:
//     -> grants in order 001,010,100,001; each separated by 102 cycles;
//        each requester's colour appears only in its own window.
//  4. Reset asserted 40 cycles into DRAW:
//     -> next cycle plot=0, busy=0, done never pulses;
//        after release, a pending req[0] is granted (ptr=0).
//  5. req[2] at x=155, y=115:
//     -> with TILE_ARB_CLIP_EN: 25 plot cycles (x 155..159, y 115..119), still 100 DRAW cycles;
//        without it: 100 plot cycles with X wrapping 255->0 impossible here,
//        but x=160..164 and y=120..124 are emitted.
//  6. req[0] changes x/colour one cycle after grant, then drops req mid-tile:
//     -> tile uses the originally latched values, completes all 100 pixels, done[0] pulses.

Source files
------------

// File: rtl/tile_draw_arbiter.sv
// tile_draw_arbiter: round-robin grant of one pixel-write port to NREQ renderers, sweeping an XDIM x YDIM tile per grant
// Ports: Clock/Reset (sync, active-high); req/req_x/req_y/req_colour packed per requester;
// grant/done one-hot pulses; busy; VGA_X/VGA_Y/VGA_COLOR/plot to the vga_adapter.
// Optional: TILE_ARB_CLIP_EN suppresses plot for pixels beyond XSCREEN/YSCREEN.
module tile_draw_arbiter #(
  parameter int NREQ    = 3,
  parameter int XDIM    = 10,
  parameter int YDIM    = 10,
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_x,
  input  logic [7*NREQ-1:0]   req_y,
  input  logic [3*NREQ-1:0]   req_colour,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic                busy,
  output logic [7:0]          VGA_X,
  output logic [6:0]          VGA_Y,
  output logic [2:0]          VGA_COLOR,
  output logic                plot
);
  localparam int PW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, sel;
  logic [3:0] xc_q, xc_d, yc_q, yc_d;
  logic [7:0] bx_q, bx_d;
  logic [6:0] by_q, by_d;
  logic [2:0] col_q, col_d;
  logic [NREQ-1:0] oh;
  logic last_x, last_y, draw;
  // Lowest k wins, so the search order is ptr, ptr+1, ... mod NREQ.
  always_comb begin
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % NREQ]) sel = PW'((int'(ptr_q) + k) % NREQ);
  end
  assign draw   = state_q == DRAW;
  assign last_x = xc_q == 4'(XDIM - 1);
  assign last_y = yc_q == 4'(YDIM - 1);
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    bx_d    = bx_q;
    by_d    = by_q;
    col_d   = col_q;
    xc_d    = draw ? (last_x ? 4'd0 : xc_q + 4'd1) : xc_q;
    yc_d    = draw && last_x ? (last_y ? 4'd0 : yc_q + 4'd1) : yc_q;
    if (state_q == IDLE && |req) begin
      state_d = DRAW;
      idx_d   = sel;
      ptr_d   = PW'((int'(sel) + 1) % NREQ);
      bx_d    = req_x[8*sel +: 8];
      by_d    = req_y[7*sel +: 7];
      col_d   = req_colour[3*sel +: 3];
      xc_d    = '0;
      yc_d    = '0;
    end
    if (draw && last_x && last_y) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      col_q   <= col_d;
    end
  end
  assign oh        = NREQ'(1) << idx_q;
  // The counters are zero only on the first DRAW cycle of a tile.
  assign grant     = draw && xc_q == '0 && yc_q == '0 ? oh : '0;
  assign done      = state_q == DONE ? oh : '0;
  assign busy      = state_q != IDLE;
  assign VGA_COLOR = col_q;
`ifdef TILE_ARB_CLIP_EN
  logic [8:0] ux;
  logic [7:0] uy;
  assign ux    = {1'b0, bx_q} + 9'(xc_q);
  assign uy    = {1'b0, by_q} + 8'(yc_q);
  assign VGA_X = ux[7:0];
  assign VGA_Y = uy[6:0];
  assign plot  = draw && ux < 9'(XSCREEN) && uy < 8'(YSCREEN);
`else
  assign VGA_X = bx_q + 8'(xc_q);
  assign VGA_Y = by_q + 7'(yc_q);
  assign plot  = draw;
`endif
endmodule

// File: tb/tb_tile_draw_arbiter.sv
// tb_tile_draw_arbiter: directed checks of arbitration order, tile sweep, reset abort, clipping and input isolation
module tb_tile_draw_arbiter;
  logic clk = 0, rst = 1;
  logic [2:0] req = 0;
  logic [23:0] req_x = 0;
  logic [20:0] req_y = 0;
  logic [8:0] req_colour = 0;
  logic [2:0] grant, done;
  logic busy, plot;
  logic [7:0] vx;
  logic [6:0] vy;
  logic [2:0] vc;
  int n_chk = 0, n_fail = 0, cyc = 0, gcyc = 0, prev_g = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  tile_draw_arbiter dut (
    .Clock(clk), .Reset(rst), .req(req), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .grant(grant), .done(done), .busy(busy), .VGA_X(vx), .VGA_Y(vy), .VGA_COLOR(vc), .plot(plot)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_x[8*i +: 8] = x;
    req_y[7*i +: 7] = y;
    req_colour[3*i +: 3] = c;
    req[i] = 1'b1;
  endtask
  task automatic wait_grant(input logic [2:0] eg);
    for (int i = 0; i < 300; i++) begin
      if (grant != 0) break;
      @(negedge clk);
    end
    check("grant", grant, eg);
    gcyc = cyc;
  endtask
  // mode 1: drop all req after grant; mode 2: alter req 0 inputs after grant, drop mid-tile
  task automatic tile(input logic [2:0] eg, input logic [2:0] ec, input logic [7:0] fx, input logic [6:0] fy,
                      input logic [7:0] lx, input logic [6:0] ly, input int ep, input int mode);
    int plots = 0, bad = 0;
    logic [7:0] x0 = 0, x1 = 0;
    logic [6:0] y0 = 0, y1 = 0;
    wait_grant(eg);
    for (int i = 0; i < 100; i++) begin
      if (i == 0) begin x0 = vx; y0 = vy; end
      if (i == 99) begin x1 = vx; y1 = vy; end
      plots += int'(plot);
      if (vc !== ec || !busy || done != 0 || (i > 0 && grant != 0)) bad++;
      if (mode == 1 && i == 1) req = 0;
      if (mode == 2 && i == 1) begin req_x[7:0] = 8'd200; req_colour[2:0] = 3'd5; end
      if (mode == 2 && i == 50) req = 0;
      @(negedge clk);
    end
    check("first_x", x0, fx);
    check("first_y", y0, fy);
    check("last_x", x1, lx);
    check("last_y", y1, ly);
    check("plot_count", plots, ep);
    check("draw_bad_cycles", bad, 0);
    check("done", done, eg);
    check("done_plot", plot, 0);
    check("done_busy", busy, 1);
  endtask
  initial begin
    int bad;
    repeat (3) @(negedge clk);
    rst = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({busy, plot, grant, done} != 0) bad++;
    end
    check("idle_quiet", bad, 0);
    check("reset_vga_x", vx, 0);
    set_req(1, 8'd80, 7'd60, 3'b100);
    tile(3'b010, 3'd4, 8'd80, 7'd60, 8'd89, 7'd69, 100, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    set_req(0, 8'd0, 7'd0, 3'd1);
    set_req(1, 8'd20, 7'd10, 3'd2);
    set_req(2, 8'd40, 7'd20, 3'd3);
    tile(3'b001, 3'd1, 8'd0, 7'd0, 8'd9, 7'd9, 100, 0);
    prev_g = gcyc;
    tile(3'b010, 3'd2, 8'd20, 7'd10, 8'd29, 7'd19, 100, 0);
    check("gap_1", gcyc - prev_g, 102);
    prev_g = gcyc;
    tile(3'b100, 3'd3, 8'd40, 7'd20, 8'd49, 7'd29, 100, 0);
    check("gap_2", gcyc - prev_g, 102);
    prev_g = gcyc;
    tile(3'b001, 3'd1, 8'd0, 7'd0, 8'd9, 7'd9, 100, 1);
    check("gap_3", gcyc - prev_g, 102);
    set_req(0, 8'd30, 7'd40, 3'd1);
    wait_grant(3'b001);
    set_req(1, 8'd50, 7'd50, 3'd7);
    repeat (40) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_vga_x", vx, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (done != 0 || grant != 0) bad++;
      @(negedge clk);
    end
    check("rst_no_done", bad, 0);
    rst = 0;
    tile(3'b001, 3'd1, 8'd30, 7'd40, 8'd39, 7'd49, 100, 1);
    @(negedge clk);
    set_req(2, 8'd155, 7'd115, 3'd6);
`ifdef TILE_ARB_CLIP_EN
    tile(3'b100, 3'd6, 8'd155, 7'd115, 8'd164, 7'd124, 25, 1);
`else
    tile(3'b100, 3'd6, 8'd155, 7'd115, 8'd164, 7'd124, 100, 1);
`endif
    @(negedge clk);
    set_req(0, 8'd10, 7'd20, 3'd2);
    tile(3'b001, 3'd2, 8'd10, 7'd20, 8'd19, 7'd29, 100, 2);
    @(negedge clk);
    check("final_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
